// File: rtl/step_moto_seq.sv
// step_moto_seq: stepper-motor move sequencer with phase table, step counting and abort.
// Optional coil release after a long idle period is enabled by defining STEP_HOLD_RELEASE_EN.
module step_moto_seq #(
    parameter int PER_W       = 32,
    parameter int CNT_W       = 16,
    parameter int POS_W       = 24,
    parameter int DEF_PERIOD  = 200000,
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    dir,
    input  logic                    half_step,
    input  logic [CNT_W-1:0]        steps,
    input  logic [PER_W-1:0]        period,
    input  logic                    abort,
    output logic [3:0]              StepDrive,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic signed [POS_W-1:0] pos
);
    typedef enum logic {IDLE, RUN} stateT;
    // Coil patterns for phases 7..0, packed so phase p sits at bits [4p+3:4p].
    localparam logic [31:0] PHASE_TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                         4'b0110, 4'b0010, 4'b0011, 4'b0001};
    stateT            state;
    logic [PER_W-1:0] tickCnt, perLat, startPer;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       phase, nextPhase;
    logic [3:0]       nextDrive;
    logic             dirLat, halfLat, stepDue;
`ifdef STEP_HOLD_RELEASE_EN
    localparam int IDLE_W = $clog2(HOLD_CYCLES + 1);
    logic [IDLE_W-1:0] idleCnt;
`endif
    // Next phase/drive for the pending step, step-due strobe and the period to latch at start.
    always_comb begin
        nextPhase = dirLat ? phase + (halfLat ? 3'd1 : 3'd2) : phase - (halfLat ? 3'd1 : 3'd2);
        nextDrive = PHASE_TBL[{nextPhase, 2'b00} +: 4];
        stepDue   = tickCnt == perLat - 1'b1;
        startPer  = period == '0 ? PER_W'(DEF_PERIOD) : period == PER_W'(1) ? PER_W'(2) : period;
    end
    // Move FSM: latch a request in IDLE, emit steps at the latched period in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            StepDrive <= '0;
            phase     <= '0;
            pos       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            tickCnt   <= '0;
            remaining <= '0;
            perLat    <= '0;
            dirLat    <= 1'b0;
            halfLat   <= 1'b0;
`ifdef STEP_HOLD_RELEASE_EN
            idleCnt   <= '0;
`endif
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (state == IDLE) begin
                if (start && steps != '0) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    dirLat    <= dir;
                    halfLat   <= half_step;
                    remaining <= steps;
                    perLat    <= startPer;
                    tickCnt   <= '0;
`ifdef STEP_HOLD_RELEASE_EN
                    idleCnt   <= '0;
`endif
                end else begin
                    done <= start;
`ifdef STEP_HOLD_RELEASE_EN
                    if (idleCnt != IDLE_W'(HOLD_CYCLES))
                        idleCnt <= idleCnt + 1'b1;
                    if (idleCnt == IDLE_W'(HOLD_CYCLES - 1))
                        StepDrive <= '0;
`endif
                end
            end else if (abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else if (stepDue) begin
                tickCnt   <= '0;
                phase     <= nextPhase;
                StepDrive <= nextDrive;
                remaining <= remaining - 1'b1;
                pos       <= dirLat ? pos + 1'b1 : pos - 1'b1;
                if (remaining == CNT_W'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                tickCnt <= tickCnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_step_moto_seq.sv
// tb_step_moto_seq: directed test of step_moto_seq against a step-schedule reference model.
module tb_step_moto_seq;
    localparam int PER_W = 32;
    localparam int CNT_W = 16;
    localparam int POS_W = 24;
    localparam int DEF_P = 20;
    localparam int HOLD  = 8;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, dir = 1'b0, halfStep = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] steps = '0;
    logic [PER_W-1:0] period = '0;
    logic [3:0] stepDrive;
    logic busy, done, aborted;
    logic signed [POS_W-1:0] pos;

    step_moto_seq #(.PER_W(PER_W), .CNT_W(CNT_W), .POS_W(POS_W), .DEF_PERIOD(DEF_P), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .half_step(halfStep), .steps(steps),
        .period(period), .abort(abort), .StepDrive(stepDrive), .busy(busy), .done(done),
        .aborted(aborted), .pos(pos)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: a move is a schedule where step k lands k*P clocks after start.
    bit mBusy = 0, mDone = 0, mAborted = 0;
    int mPos = 0, mPhase = 0, mP = 1, mN = 0, mSign = 1, mInc = 1, mBasePos = 0, mBasePhase = 0;
    int mElapsed = 0, mIdle = 0, mK = 0;
    logic [3:0] mDrive = 4'b0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mBusy = 0; mDone = 0; mAborted = 0; mPos = 0; mPhase = 0; mDrive = 4'b0; mIdle = 0;
        end else begin
            mDone = 0;
            mAborted = 0;
            if (!mBusy) begin
                if (start && steps != 0) begin
                    mP = period == 0 ? DEF_P : period == 1 ? 2 : int'(period);
                    mN = int'(steps);
                    mSign = dir ? 1 : -1;
                    mInc = halfStep ? 1 : 2;
                    mBasePos = mPos;
                    mBasePhase = mPhase;
                    mElapsed = 0;
                    mBusy = 1;
                    mIdle = 0;
                end else begin
                    mDone = start;
                    mIdle++;
`ifdef STEP_HOLD_RELEASE_EN
                    if (mIdle >= HOLD) mDrive = 4'b0;
`endif
                end
            end else if (abort) begin
                mBusy = 0;
                mAborted = 1;
            end else begin
                mElapsed++;
                if (mElapsed % mP == 0) begin
                    mK = mElapsed / mP;
                    mPos = mBasePos + mSign * mK;
                    mPhase = (mBasePhase + mSign * mInc * mK) & 7;
                    mDrive = tbl[mPhase];
                    if (mK == mN) begin
                        mBusy = 0;
                        mDone = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    initial forever begin
        @(negedge clk);
        check("cyc_drive", {28'b0, stepDrive}, {28'b0, mDrive});
        check("cyc_busy", {31'b0, busy}, {31'b0, mBusy});
        check("cyc_done", {31'b0, done}, {31'b0, mDone});
        check("cyc_aborted", {31'b0, aborted}, {31'b0, mAborted});
        check("cyc_pos", {8'b0, pos}, {8'b0, POS_W'(mPos)});
    end

    int nBusy, nDone, nAbort, doneAt;
    logic [3:0] chg[$];
    int chgAt[$];

    // Observe n cycles after a start edge; abort is raised so it is sampled on edge abortAt.
    task automatic run(int n, int abortAt);
        logic [3:0] prev;
        prev = stepDrive;
        nBusy = 0; nDone = 0; nAbort = 0; doneAt = -1;
        chg.delete();
        chgAt.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) nBusy++;
            if (done) begin nDone++; if (doneAt < 0) doneAt = i; end
            if (aborted) nAbort++;
            if (stepDrive !== prev) begin chg.push_back(stepDrive); chgAt.push_back(i); prev = stepDrive; end
            start = 1'b0;
            abort = (i + 1 == abortAt);
            if (i == 0) begin
                dir = 1'($urandom);
                halfStep = 1'($urandom);
                steps = CNT_W'($urandom);
                period = PER_W'($urandom);
            end
        end
    endtask

    task automatic go(int s, bit d, bit h, int p, int n, int abortAt);
        steps = CNT_W'(s);
        dir = d;
        halfStep = h;
        period = PER_W'(p);
        start = 1'b1;
        run(n, abortAt);
    endtask

    function automatic logic [3:0] chgVal(int i);
        return i < chg.size() ? chg[i] : 4'hx;
    endfunction

    function automatic int chgTime(int i);
        return i < chgAt.size() ? chgAt[i] : -1;
    endfunction

    initial begin
        logic [3:0] e1 [4] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100};
        logic [3:0] e2 [3] = '{4'b1000, 4'b0100, 4'b0010};
        int a;
        repeat (2) @(negedge clk);
        check("rst_drive", {28'b0, stepDrive}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_pos", {8'b0, pos}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        go(4, 1, 1, 10, 45, -1);
        check("s1_busy_len", nBusy, 40);
        check("s1_done_cnt", nDone, 1);
        check("s1_nsteps", chg.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("s1_seq", {28'b0, chgVal(i)}, {28'b0, e1[i]});
            check("s1_time", chgTime(i), 10 * (i + 1));
        end
        check("s1_pos", {8'b0, pos}, 32'd4);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        go(3, 0, 0, 4, 14, -1);
        check("s2_nsteps", chg.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("s2_seq", {28'b0, chgVal(i)}, {28'b0, e2[i]});
            check("s2_time", chgTime(i), 4 * (i + 1));
        end
        check("s2_pos", {8'b0, pos}, 32'h00FFFFFD);
        check("s2_done_cnt", nDone, 1);
        go(100, 1, 1, 5, 45, 40);
        check("s3_nsteps", chg.size(), 7);
        check("s3_aborted", nAbort, 1);
        check("s3_done", nDone, 0);
        check("s3_busy_len", nBusy, 40);
        check("s3_pos", {8'b0, pos}, 32'd4);
        check("s3_drive", {28'b0, stepDrive}, 32'b0011);
        go(0, 1, 1, 10, 5, -1);
        check("s4_done_cnt", nDone, 1);
        check("s4_done_at", doneAt, 0);
        check("s4_busy", nBusy, 0);
        check("s4_nsteps", chg.size(), 0);
        go(1, 1, 1, 0, 25, -1);
        check("s4_defper_time", chgTime(0), DEF_P);
        check("s4_defper_drive", {28'b0, stepDrive}, 32'b0010);
        go(2, 1, 1, 1, 6, -1);
        check("s4_per1_t0", chgTime(0), 2);
        check("s4_per1_t1", chgTime(1), 4);
        check("s4_per1_pos", {8'b0, pos}, 32'd7);
        abort = 1'b1;
        a = 0;
        repeat (3) begin @(negedge clk); a += int'(aborted) + int'(busy); end
        abort = 1'b0;
        check("idle_abort", a, 0);
        go(10, 1, 1, 3, 7, -1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_drive", {28'b0, stepDrive}, 32'h0);
        check("mid_rst_pos", {8'b0, pos}, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_pulses", {30'b0, done, aborted}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        go(2, 1, 1, 3, 8, -1);
        check("hold_move_drive", {28'b0, stepDrive}, 32'b0010);
        run(12, -1);
`ifdef STEP_HOLD_RELEASE_EN
        check("hold_release", {28'b0, stepDrive}, 32'h0);
`else
        check("hold_keep", {28'b0, stepDrive}, 32'b0010);
`endif
        go(1, 1, 1, 3, 5, -1);
        check("hold_resume_drive", {28'b0, stepDrive}, 32'b0110);
        check("hold_resume_pos", {8'b0, pos}, 32'd3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/step_moto_seq.md
STEP_MOTO_SEQ -- requirements
Module: step_moto_seq

Interface
REQ-001 Parameter PER_W, default 32, width of the step-period counter and the `period` input.
REQ-002 Parameter CNT_W, default 16, width of the `steps` input and the remaining-step counter.
REQ-003 Parameter POS_W, default 24, width of the signed `pos` output.
REQ-004 Parameter DEF_PERIOD, default 200000, clocks per step used when `period` is 0.
REQ-005 Parameter HOLD_CYCLES, default 5000000, idle clocks before coil release (used only under REQ-026).
REQ-006 Port `clk`, input, 1 bit, single clock; all logic samples on its rising edge.
REQ-007 Port `rst`, input, 1 bit, reset, asynchronous, active-low.
REQ-008 Port `start`, input, 1 bit, move request, sampled in IDLE only.
REQ-009 Port `dir`, input, 1 bit, 1 = forward (phase +), 0 = reverse (phase -).
REQ-010 Port `half_step`, input, 1 bit, 1 = 8-phase half-step, 0 = full-step (phase ±2).
REQ-011 Port `steps`, input, CNT_W bits, number of steps to move.
REQ-012 Port `period`, input, PER_W bits, clocks per step.
REQ-013 Port `abort`, input, 1 bit, stop the move in progress.
REQ-014 Port `StepDrive`, output, 4 bits, coil drive.
REQ-015 Port `busy`, output, 1 bit, high while in RUN.
REQ-016 Port `done`, output, 1 bit, 1-cycle pulse on normal completion.
REQ-017 Port `aborted`, output, 1 bit, 1-cycle pulse on abort.
REQ-018 Port `pos`, output, POS_W bits, signed, absolute step position.

Function
REQ-019 The FSM SHALL have exactly two states, IDLE and RUN.
- IDLE -> RUN when `start`=1 and `steps`≠0.
- On that transition, latch `dir`, `half_step` and `steps`.
- On that transition, latch the period: `period`=0 latches DEF_PERIOD; `period`=1 latches 2; any other value latches unchanged.
- On that transition, clear the tick counter.
- `busy`=1 from the next cycle.
REQ-020 `start`=1 with `steps`=0 in IDLE SHALL produce a `done` pulse on the next cycle, with no state change and no motion.
REQ-021 In RUN, the tick counter SHALL increment every clock. When it equals latched period−1:
- tick counter -> 0;
- phase index (3-bit, wraps modulo 8) advances by +1/−1 (half-step) or +2/−2 (full-step) per `dir`;
- StepDrive is loaded from the table entry of the new phase;
- remaining -> remaining−1;
- `pos` -> `pos`±1, wrapping two's-complement.
REQ-022 Phase table SHALL be: 0:0001, 1:0011, 2:0010, 3:0110, 4:0100, 5:1100, 6:1000, 7:1001.
REQ-023 On the step where remaining reaches 0, the FSM SHALL go to IDLE, with `busy`=0 and `done`=1 on the following cycle. The first step therefore occurs `period` clocks after `busy` rises, and a move of N steps lasts N×period clocks.
REQ-024 `abort`=1 in RUN SHALL force IDLE on the next edge and pulse `aborted` for one cycle; `done` is not pulsed and the step due on that same cycle is not taken (abort wins). Inputs `start`, `dir`, `half_step`, `steps` and `period` SHALL be ignored while in RUN. `abort` in IDLE has no effect.
REQ-025 In IDLE, StepDrive, phase and `pos` SHALL hold their values (holding torque).

Configuration
REQ-026 Macro STEP_HOLD_RELEASE_EN controls coil release.
- When defined: an idle counter counts clocks in IDLE. After HOLD_CYCLES consecutive IDLE clocks, StepDrive -> 0000 while phase and `pos` are retained. The next move resumes from the retained phase, and the counter clears on entry to RUN.
- When undefined: no idle counter exists and StepDrive holds indefinitely.

Reset
REQ-027 While `rst`=0, the block SHALL be asynchronously forced to: FSM=IDLE, StepDrive=0000, phase=0, `pos`=0, `busy`=0, `done`=0, `aborted`=0, tick counter=0, remaining=0, idle counter=0. Reset mid-move SHALL discard the move with no `done` or `aborted` pulse.

Verification
REQ-028 Scenario: reset, then `start` with `steps`=4, `dir`=1, `half_step`=1, `period`=10. Required response: StepDrive = 0011, 0010, 0110, 0100 at 10-clock spacing; `pos`=4; `done` is pulsed once; `busy` is high for 40 clocks.
REQ-029 Scenario: from phase 0, `steps`=3, `dir`=0, `half_step`=0, `period`=4. Required response: phase sequence 6, 4, 2; StepDrive = 1000, 0100, 0010; `pos`=−3.
REQ-030 Scenario: `steps`=100, `period`=5, `abort` asserted on the cycle a step is due after 7 steps. Required response: `pos`=7; `aborted` pulses; no `done`; the 8th step is not taken.
REQ-031 Scenario: `start` with `steps`=0. Required response: `done` pulses next cycle, `busy` stays 0, StepDrive is unchanged. Also `period`=0: the first step occurs after exactly 200000 clocks.
REQ-032 Scenario: `rst` pulsed low mid-move. Required response: all outputs are at reset values immediately and `pos`=0.
REQ-033 Scenario, with STEP_HOLD_RELEASE_EN defined and HOLD_CYCLES=8: after a move completes, StepDrive -> 0000 after 8 idle clocks. The next 1-step forward half-step move then drives the table entry for phase+1.
